jump_addr_sequencer: RTL and testbench
======================================

// Module: jump_addr_sequencer
// PURPOSE
// - Sequences the two-byte address load for GOTO/CALL-type instructions.
// - Fetches the high byte from memory into J1 and the low byte into J2,
//   then gates J1:J2 onto the address bus and loads the program counter.
// - Sits between the instruction decoder (start) and the J1/J2 register
//   control lines plus the memory read handshake.
// - Replaces hand-timed relay pulse chains with a clocked state machine.
// PARAMETERS
// - SETTLE_CYCLES  2   cycles each load/select strobe is held (relay settle), >=1
// - ACK_TIMEOUT    15  max cycles to wait for mem_ack in a read state, >=1
// PORTS
// - clk       in   1  single system clock, rising edge
// - rst_n     in   1  reset: synchronous, active-low
// - start     in   1  decoder request; sampled only in IDLE
// - mem_ack   in   1  memory has valid byte on data bus
// - cond_ok   in   1  jump condition (present only with JUMP_COND_EN)
// - mem_req   out  1  memory read request; drives byte onto data bus
// - inc_pc    out  1  one-cycle PC increment pulse between bytes
// - ld_j1     out  1  load strobe to J1 (high address byte)
// - ld_j2     out  1  load strobe to J2 (low address byte)
// - sel_j     out  1  gate J1:J2 onto 16-bit address bus
// - ld_pc     out  1  load PC from address bus
// - busy      out  1  high in every state except IDLE
// - done      out  1  one-cycle completion pulse
// - taken     out  1  valid with done: 1 = PC was loaded
// - err       out  1  one-cycle pulse on mem_ack timeout
// BEHAVIOUR
// - Reset (rst_n=0 at edge): state=IDLE, counters=0, all outputs 0.
//   Applies mid-sequence; strobes drop at that same edge, no partial PC load.
// - States: IDLE, RD1, LD1, INC, RD2, LD2, XFER, DONE.
// - IDLE: start=1 -> RD1 next cycle. start outside IDLE is ignored.
// - RD1/RD2: mem_req=1; wait counter increments each cycle.
//   mem_ack=1 -> LD1/LD2 with counter cleared.
//   Counter reaching ACK_TIMEOUT without ack -> IDLE, err=1 for that cycle,
//   no ld_* asserted, J1/J2 contents undefined.
// - LD1/LD2: mem_req stays 1 (bus held); ld_j1/ld_j2=1 for exactly
//   SETTLE_CYCLES cycles. LD1 -> INC; LD2 -> XFER (or DONE, see config).
// - INC: inc_pc=1 for one cycle, mem_req=0 -> RD2.
// - XFER: sel_j=1 for SETTLE_CYCLES cycles; ld_pc=1 in the last of those
//   cycles only. Then -> DONE.
// - DONE: done=1 for one cycle, taken valid -> IDLE.
//   start in the DONE cycle is ignored; accepted from IDLE next cycle.
// - Strobes are mutually exclusive: at most one of ld_j1, ld_j2, ld_pc, and
//   inc_pc high in any cycle. mem_ack is ignored outside RD states.
// - Nominal latency, start to done, with immediate ack and default
//   parameters: 1+1+2+1+1+2+2+1 = 11 cycles.
//   Settle counter: $clog2(SETTLE_CYCLES+1) bits.
//   Wait counter: $clog2(ACK_TIMEOUT+1) bits. No wrap (saturating compare).
// CONFIGURATION
// - JUMP_COND_EN defined: cond_ok port exists; sampled in the final LD2
//   cycle. If 1 -> XFER and taken=1. If 0 -> DONE directly with taken=0;
//   sel_j and ld_pc are never asserted. Bytes are still fetched (PC advances).
// - JUMP_COND_EN undefined: no cond_ok port; always XFER; taken=1 with done.
// TESTING
// - Unconditional jump: start pulse, ack 1 cycle after each mem_req, bytes
//   0x12/0x34 -> ld_j1 2 cycles, inc_pc 1, ld_j2 2, sel_j 2, ld_pc 1,
//   done+taken at cycle 11.
// - Slow memory: ack delayed 5 cycles on RD2 -> same strobe order, done
//   5 cycles later, err=0.
// - Timeout: mem_ack held 0 -> err pulse after ACK_TIMEOUT=15 cycles in RD1,
//   no ld_j1/ld_pc, busy=0 next cycle.
// - Reset mid-op: rst_n=0 during LD2 -> all outputs 0 after edge. Start after
//   release runs a clean full sequence.
// - JUMP_COND_EN, cond_ok=0 -> both bytes loaded, sel_j/ld_pc never high,
//   done=1, taken=0. With cond_ok=1 -> taken=1.
// - start held high continuously -> back-to-back sequences, one IDLE cycle
//   between done and next mem_req, no overlapping strobes.

Source files
------------

// File: rtl/jump_addr_sequencer.sv
// jump_addr_sequencer
// Clocked sequencer for the two-byte GOTO/CALL address load: fetch the high
// byte into J1 and the low byte into J2, then gate J1:J2 onto the address bus
// and load the program counter.
// Optional feature macro: JUMP_COND_EN adds the cond_ok input. When cond_ok is
// low in the final LD2 cycle, the transfer is skipped and done reports taken=0.
// All outputs are registered. They are decoded from the next state, so each
// output lines up with the state it belongs to.
module jump_addr_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ACK_TIMEOUT   = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic mem_ack,
`ifdef JUMP_COND_EN
    input  logic cond_ok,
`endif
    output logic mem_req,
    output logic inc_pc,
    output logic ld_j1,
    output logic ld_j2,
    output logic sel_j,
    output logic ld_pc,
    output logic busy,
    output logic done,
    output logic taken,
    output logic err
);

    localparam int SW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam int WW = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

    // Last count value of a settle window and of an ack wait window.
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST   = WW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD1  = 3'd1,
        S_LD1  = 3'd2,
        S_INC  = 3'd3,
        S_RD2  = 3'd4,
        S_LD2  = 3'd5,
        S_XFER = 3'd6,
        S_DONE = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          taken_q, taken_d;
    logic          err_d;

    logic mem_req_q, inc_pc_q, ld_j1_q, ld_j2_q, sel_j_q, ld_pc_q;
    logic busy_q, done_q, taken_out_q, err_q;

    // Next-state, counter and condition-latch logic.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        wait_d   = wait_q;
        taken_d  = taken_q;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RD1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD1, S_RD2: begin
                if (mem_ack) begin
                    state_d = (state_q == S_RD1) ? S_LD1 : S_LD2;
                    wait_d  = {WW{1'b0}};
                end else if (wait_q >= WAIT_LAST) begin
                    // Compare with >= so the counter can never wrap.
                    state_d = S_IDLE;
                    wait_d  = {WW{1'b0}};
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_LD1: begin
                if (settle_q >= SETTLE_LAST) begin
                    state_d  = S_INC;
                    settle_d = {SW{1'b0}};
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            S_INC: begin
                state_d = S_RD2;
            end
            S_LD2: begin
                if (settle_q >= SETTLE_LAST) begin
                    settle_d = {SW{1'b0}};
`ifdef JUMP_COND_EN
                    // The condition is sampled once, in the final LD2 cycle.
                    taken_d = cond_ok;
                    state_d = cond_ok ? S_XFER : S_DONE;
`else
                    taken_d = 1'b1;
                    state_d = S_XFER;
`endif
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            S_XFER: begin
                if (settle_q >= SETTLE_LAST) begin
                    state_d  = S_DONE;
                    settle_d = {SW{1'b0}};
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                settle_d = {SW{1'b0}};
                wait_d   = {WW{1'b0}};
            end
        endcase
    end

    // State, counter and registered output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            settle_q    <= {SW{1'b0}};
            wait_q      <= {WW{1'b0}};
            taken_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            inc_pc_q    <= 1'b0;
            ld_j1_q     <= 1'b0;
            ld_j2_q     <= 1'b0;
            sel_j_q     <= 1'b0;
            ld_pc_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            taken_out_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            wait_q      <= wait_d;
            taken_q     <= taken_d;
            // The bus stays requested through LD so the byte is held while J latches.
            mem_req_q   <= (state_d == S_RD1) || (state_d == S_LD1) ||
                           (state_d == S_RD2) || (state_d == S_LD2);
            inc_pc_q    <= (state_d == S_INC);
            ld_j1_q     <= (state_d == S_LD1);
            ld_j2_q     <= (state_d == S_LD2);
            sel_j_q     <= (state_d == S_XFER);
            ld_pc_q     <= (state_d == S_XFER) && (settle_d == SETTLE_LAST);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
            taken_out_q <= (state_d == S_DONE) && taken_d;
            err_q       <= err_d;
        end
    end

    assign mem_req = mem_req_q;
    assign inc_pc  = inc_pc_q;
    assign ld_j1   = ld_j1_q;
    assign ld_j2   = ld_j2_q;
    assign sel_j   = sel_j_q;
    assign ld_pc   = ld_pc_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign taken   = taken_out_q;
    assign err     = err_q;

endmodule

// File: tb/tb_jump_addr_sequencer.sv
// Testbench for jump_addr_sequencer.
// The reference model builds the expected output for every cycle of a
// transaction from the phase lengths: read wait plus one, settle windows,
// the one-cycle INC phase and the one-cycle DONE phase.
// The memory acks after a random delay. Random start and mem_ack values are
// injected where the design must ignore them.
module tb_jump_addr_sequencer;

    localparam int SETTLE = 2;
    localparam int TO     = 15;

    // Bit order: {mem_req, inc_pc, ld_j1, ld_j2, sel_j, ld_pc, busy, done, taken, err}
    localparam logic [9:0] V_IDLE   = 10'b0000000000;
    localparam logic [9:0] V_RD     = 10'b1000001000;
    localparam logic [9:0] V_LD1    = 10'b1010001000;
    localparam logic [9:0] V_INC    = 10'b0100001000;
    localparam logic [9:0] V_LD2    = 10'b1001001000;
    localparam logic [9:0] V_XFER   = 10'b0000101000;
    localparam logic [9:0] V_XFER_L = 10'b0000111000;
    localparam logic [9:0] V_DONE_T = 10'b0000001110;
    localparam logic [9:0] V_DONE_N = 10'b0000001100;
    localparam logic [9:0] V_ERR    = 10'b0000000001;

    logic clk = 1'b0;
    logic rst_n, start, mem_ack, cond_ok;
    logic mem_req, inc_pc, ld_j1, ld_j2, sel_j, ld_pc, busy, done, taken, err;

    int compared   = 0;
    int mismatched = 0;
    int cycle_no   = 0;
    int lat;

    always #5 clk = ~clk;

    jump_addr_sequencer #(
        .SETTLE_CYCLES(SETTLE),
        .ACK_TIMEOUT  (TO)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mem_ack(mem_ack),
`ifdef JUMP_COND_EN
        .cond_ok(cond_ok),
`endif
        .mem_req(mem_req),
        .inc_pc (inc_pc),
        .ld_j1  (ld_j1),
        .ld_j2  (ld_j2),
        .sel_j  (sel_j),
        .ld_pc  (ld_pc),
        .busy   (busy),
        .done   (done),
        .taken  (taken),
        .err    (err)
    );

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: check the outputs just after the edge, then drive the
    // inputs that the next edge will sample.
    task automatic cyc(input logic [9:0] exp, input logic r, input logic st,
                       input logic ak, input logic cd, input string tag);
        logic [9:0] obs;
        @(posedge clk);
        #1;
        cycle_no++;
        obs = {mem_req, inc_pc, ld_j1, ld_j2, sel_j, ld_pc, busy, done, taken, err};
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cycle_no, obs, exp);
        end
        rst_n   = r;
        start   = st;
        mem_ack = ak;
        cond_ok = cd;
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(V_IDLE, 1'b1, 1'b0, rnd(), rnd(), "idle");
        end
    endtask

    // Runs one transaction, starting from an IDLE cycle.
    // d1 and d2 are the ack delays in cycles; a value of TO or more means no ack.
    // held keeps start high in every cycle.
    // rst_ld2 pulls reset during the first LD2 cycle.
    // latency is the number of cycles from start to done, inclusive, or -1 if
    // the transaction aborted.
    task automatic run_txn(input int d1, input int d2, input logic cnd,
                           input logic held, input logic rst_ld2, output int latency);
        int   t0;
        logic ak;
        logic tk;
        t0 = cycle_no + 1;
        cyc(V_IDLE, 1'b1, 1'b1, rnd(), rnd(), "idle_start");
        for (int k = 0; k < TO; k++) begin
            ak = (k == d1);
            cyc(V_RD, 1'b1, held ? 1'b1 : rnd(), ak, rnd(), "rd1");
            if (ak) break;
        end
        if (d1 >= TO) begin
            cyc(V_ERR, 1'b1, 1'b0, rnd(), rnd(), "rd1_timeout");
            latency = -1;
            return;
        end
        for (int k = 0; k < SETTLE; k++) begin
            cyc(V_LD1, 1'b1, held ? 1'b1 : rnd(), rnd(), rnd(), "ld1");
        end
        cyc(V_INC, 1'b1, held ? 1'b1 : rnd(), rnd(), rnd(), "inc");
        for (int k = 0; k < TO; k++) begin
            ak = (k == d2);
            cyc(V_RD, 1'b1, held ? 1'b1 : rnd(), ak, rnd(), "rd2");
            if (ak) break;
        end
        if (d2 >= TO) begin
            cyc(V_ERR, 1'b1, 1'b0, rnd(), rnd(), "rd2_timeout");
            latency = -1;
            return;
        end
        for (int k = 0; k < SETTLE; k++) begin
            if (rst_ld2 && k == 0) begin
                cyc(V_LD2, 1'b0, 1'b0, rnd(), rnd(), "ld2");
                cyc(V_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, "reset_mid");
                latency = -1;
                return;
            end
            cyc(V_LD2, 1'b1, held ? 1'b1 : rnd(), rnd(),
                (k == SETTLE - 1) ? cnd : rnd(), "ld2");
        end
`ifdef JUMP_COND_EN
        tk = cnd;
`else
        tk = 1'b1;
`endif
        if (tk) begin
            for (int k = 0; k < SETTLE; k++) begin
                cyc((k == SETTLE - 1) ? V_XFER_L : V_XFER, 1'b1,
                    held ? 1'b1 : rnd(), rnd(), rnd(), "xfer");
            end
        end
        cyc(tk ? V_DONE_T : V_DONE_N, 1'b1, held ? 1'b1 : rnd(), rnd(), rnd(), "done");
        latency = cycle_no - t0 + 1;
    endtask

    initial begin
        int d1, d2;
        logic cnd, held;
        rst_n   = 1'b0;
        start   = 1'b0;
        mem_ack = 1'b0;
        cond_ok = 1'b0;

        // Reset state, then release.
        cyc(V_IDLE, 1'b0, 1'b1, 1'b1, 1'b0, "reset");
        cyc(V_IDLE, 1'b0, 1'b1, 1'b1, 1'b0, "reset");
        cyc(V_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, "reset_release");
        idle_cycles(2);

        // Unconditional jump with immediate ack.
        run_txn(0, 0, 1'b1, 1'b0, 1'b0, lat);
        check_int("latency_nominal", lat, 11);
        idle_cycles(1);

        // Slow memory: the RD2 ack arrives 5 cycles late.
        run_txn(0, 5, 1'b1, 1'b0, 1'b0, lat);
        check_int("latency_slow_rd2", lat, 16);
        idle_cycles(1);

        // Timeout in RD1 and in RD2.
        run_txn(TO, 0, 1'b1, 1'b0, 1'b0, lat);
        idle_cycles(2);
        run_txn(3, TO, 1'b1, 1'b0, 1'b0, lat);
        idle_cycles(1);

        // Reset during LD2, then a clean full sequence.
        run_txn(1, 2, 1'b1, 1'b0, 1'b1, lat);
        idle_cycles(1);
        run_txn(0, 0, 1'b1, 1'b0, 1'b0, lat);
        check_int("latency_after_reset", lat, 11);
        idle_cycles(1);

        // Condition low, then high.
        run_txn(0, 0, 1'b0, 1'b0, 1'b0, lat);
`ifdef JUMP_COND_EN
        check_int("latency_cond_low", lat, 9);
`else
        check_int("latency_cond_low", lat, 11);
`endif
        run_txn(0, 0, 1'b1, 1'b0, 1'b0, lat);
        check_int("latency_cond_high", lat, 11);

        // Start held high: back-to-back sequences with one IDLE cycle between.
        for (int i = 0; i < 3; i++) begin
            run_txn(0, 1, 1'b1, 1'b1, 1'b0, lat);
            check_int("latency_back_to_back", lat, 12);
        end
        idle_cycles(1);

        // Random transactions.
        for (int i = 0; i < 40; i++) begin
            d1   = int'($urandom_range(0, 17));
            d2   = int'($urandom_range(0, 17));
            cnd  = rnd();
            held = rnd();
            run_txn(d1, d2, cnd, held, 1'b0, lat);
            if (held && lat < 0) begin
                idle_cycles(1);
            end else begin
                idle_cycles(int'($urandom_range(0, 2)));
            end
        end
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
